// File: rtl/river_pkg.sv
// Shared types and the bank-safety rule for the river-crossing game controller.
package river_pkg;

  typedef enum logic [1:0] {
    PLAY,
    CROSS,
    LOST,
    WON
  } state_e;

  typedef enum logic [1:0] {
    P_NONE,
    P_G,
    P_W,
    P_F
  } passenger_e;

  // Unsafe when a conflicting pair (G,W) or (W,F) shares a bank that C has left.
  function automatic logic is_unsafe(input logic c, input logic g, input logic w,
                                     input logic f);
    return ((g == w) && (c != g)) || ((w == f) && (c != w));
  endfunction

endpackage

// File: rtl/bcd_move_counter.sv
// Two-digit BCD move counter, incremented once per completed crossing, saturating at 99.
module bcd_move_counter (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max;

  assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc && !at_max) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/river_crossing_ctrl.sv
// River-crossing game controller: button edge detection, crossing timer, bank positions,
// lose/win detection and BCD move count.
module river_crossing_ctrl
  import river_pkg::*;
#(
  parameter int unsigned CROSS_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BtnC,
  input  logic       BtnG,
  input  logic       BtnW,
  input  logic       BtnF,
  output logic       C,
  output logic       G,
  output logic       W,
  output logic       F,
  output logic       InTransit,
  output logic       Lost,
  output logic       Won,
  output logic [3:0] MovesTens,
  output logic [3:0] MovesOnes
);

  localparam logic [7:0] TimerLoad = 8'(CROSS_CYCLES - 1);

  logic [3:0] btn, prev_q, rise;
  state_e     state_q, state_d;
  passenger_e pass_q, pass_d, req_pass;
  logic [7:0] timer_q, timer_d;
  logic       c_q, c_d, g_q, g_d, w_q, w_d, f_q, f_d;
  logic       req_valid;
  logic       done;

  assign btn  = {BtnF, BtnW, BtnG, BtnC};
  assign rise = btn & ~prev_q;

  // Only a single rising button counts; a passenger must share C's bank.
  always_comb begin
    req_valid = 1'b0;
    req_pass  = P_NONE;
    unique case (rise)
      4'b0001: req_valid = 1'b1;
      4'b0010: begin
        req_valid = (g_q == c_q);
        req_pass  = P_G;
      end
      4'b0100: begin
        req_valid = (w_q == c_q);
        req_pass  = P_W;
      end
      4'b1000: begin
        req_valid = (f_q == c_q);
        req_pass  = P_F;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    timer_d = timer_q;
    c_d     = c_q;
    g_d     = g_q;
    w_d     = w_q;
    f_d     = f_q;
    done    = 1'b0;
    unique case (state_q)
      PLAY: begin
        if (req_valid) begin
          pass_d  = req_pass;
          timer_d = TimerLoad;
          state_d = CROSS;
        end
      end
      CROSS: begin
        if (timer_q == 8'd0) begin
          done = 1'b1;
          c_d  = ~c_q;
          case (pass_q)
            P_G:     g_d = ~g_q;
            P_W:     w_d = ~w_q;
            P_F:     f_d = ~f_q;
            default: ;
          endcase
          if (c_d && g_d && w_d && f_d) begin
            state_d = WON;
          end else if (is_unsafe(c_d, g_d, w_d, f_d)) begin
            state_d = LOST;
          end else begin
            state_d = PLAY;
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      LOST, WON: ;
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      prev_q  <= 4'b0000;
      state_q <= PLAY;
      pass_q  <= P_NONE;
      timer_q <= 8'd0;
      c_q     <= 1'b0;
      g_q     <= 1'b0;
      w_q     <= 1'b0;
      f_q     <= 1'b0;
    end else begin
      prev_q  <= btn;
      state_q <= state_d;
      pass_q  <= pass_d;
      timer_q <= timer_d;
      c_q     <= c_d;
      g_q     <= g_d;
      w_q     <= w_d;
      f_q     <= f_d;
    end
  end

  bcd_move_counter u_moves (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (done),
    .tens  (MovesTens),
    .ones  (MovesOnes)
  );

  assign C         = c_q;
  assign G         = g_q;
  assign W         = w_q;
  assign F         = f_q;
  assign InTransit = (state_q == CROSS);
  assign Lost      = (state_q == LOST);
  assign Won       = (state_q == WON);

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Scoreboard bench for river_crossing_ctrl: directed game scenarios plus random presses
// checked against a bank/move model of the game rules.
module tb_river_crossing_ctrl;

  localparam int unsigned CROSS = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       BtnC, BtnG, BtnW, BtnF;
  logic       C, G, W, F, InTransit, Lost, Won;
  logic [3:0] MovesTens, MovesOnes;

  river_crossing_ctrl #(.CROSS_CYCLES(CROSS)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .BtnC      (BtnC),
    .BtnG      (BtnG),
    .BtnW      (BtnW),
    .BtnF      (BtnF),
    .C         (C),
    .G         (G),
    .W         (W),
    .F         (F),
    .InTransit (InTransit),
    .Lost      (Lost),
    .Won       (Won),
    .MovesTens (MovesTens),
    .MovesOnes (MovesOnes)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [14:0] exp;
  } item_t;

  item_t sb[$];

  // Game model: index 0..3 = C, G, W, F.
  logic m_pos[4];
  int   m_moves;
  logic m_lost, m_won;

  function automatic logic [14:0] model_vec(input logic transit);
    logic [3:0] tens, ones;
    tens = 4'(m_moves / 10);
    ones = 4'(m_moves % 10);
    return {m_pos[0], m_pos[1], m_pos[2], m_pos[3], transit, m_lost, m_won, tens, ones};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {C, G, W, F, InTransit, Lost, Won, MovesTens, MovesOnes};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got CGWF/T/L/W/moves=%b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pos[i] = 1'b0;
    m_moves = 0;
    m_lost  = 1'b0;
    m_won   = 1'b0;
  endtask

  task automatic model_request(input logic [3:0] mask, output bit acc);
    int k;
    acc = 1'b0;
    if (m_lost || m_won || $countones(mask) != 1) return;
    k = 0;
    for (int i = 0; i < 4; i++) if (mask[i]) k = i;
    if (k != 0 && m_pos[k] != m_pos[0]) return;
    acc = 1'b1;
    m_pos[0] = ~m_pos[0];
    if (k != 0) m_pos[k] = ~m_pos[k];
    m_moves = (m_moves < 99) ? m_moves + 1 : 99;
    m_won   = m_pos[0] && m_pos[1] && m_pos[2] && m_pos[3];
    m_lost  = !m_won && (((m_pos[1] == m_pos[2]) && (m_pos[0] != m_pos[1])) ||
                         ((m_pos[2] == m_pos[3]) && (m_pos[0] != m_pos[2])));
  endtask

  task automatic do_reset(input int n);
    @(posedge Clock);
    #1 Reset = 1'b1;
    repeat (n) @(posedge Clock);
    #1 Reset = 1'b0;
    model_reset();
  endtask

  // Press mask for `hold` cycles, release, let any crossing finish, then compare settled state.
  task automatic press(input logic [3:0] mask, input int hold);
    bit acc;
    @(posedge Clock);
    #1 {BtnF, BtnW, BtnG, BtnC} = mask;
    model_request(mask, acc);
    if (acc) sb.push_back('{t: cyc, exp: model_vec(1'b0)});
    repeat (hold) @(posedge Clock);
    #1 {BtnF, BtnW, BtnG, BtnC} = 4'b0000;
    repeat (CROSS + 2) @(posedge Clock);
    @(negedge Clock);
    check("settle", dut_vec(), model_vec(1'b0));
  endtask

  // Monitor: each completed InTransit run pops one expected crossing.
  bit    in_run   = 1'b0;
  int    run_len  = 0;
  int    run_start = 0;
  item_t it;

  always @(negedge Clock) begin
    if (Reset) begin
      in_run  = 1'b0;
      run_len = 0;
      sb.delete();
    end else if (InTransit) begin
      if (!in_run) begin
        in_run    = 1'b1;
        run_start = cyc;
        run_len   = 0;
      end
      run_len++;
    end else if (in_run) begin
      in_run = 1'b0;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_crossing @cyc %0d: got crossing expected none", cyc);
      end else begin
        it = sb.pop_front();
        check_int("transit_start", run_start, it.t + 1);
        check_int("transit_len", run_len, CROSS);
        check("crossing_result", dut_vec(), it.exp);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    {BtnF, BtnW, BtnG, BtnC} = 4'b0000;
    model_reset();
    do_reset(2);

    repeat (10) begin
      @(negedge Clock);
      check("idle", dut_vec(), model_vec(1'b0));
    end

    // C alone leaves G with W: lost; later presses ignored.
    press(4'b0001, 1);
    check_int("lost_flag", int'(Lost), 1);
    press(4'b0100, 1);

    // W across, then G is on the other bank: ignored.
    do_reset(1);
    press(4'b0100, 1);
    press(4'b0010, 1);

    // Seven-move solution W, C, G, W, F, C, W, then a terminal press.
    do_reset(1);
    press(4'b0100, 1);
    press(4'b0001, 1);
    press(4'b0010, 1);
    press(4'b0100, 1);
    press(4'b1000, 1);
    press(4'b0001, 1);
    press(4'b0100, 1);
    check_int("won_flag", int'(Won), 1);
    check_int("won_moves", int'({MovesTens, MovesOnes}), 8'h07);
    press(4'b0001, 1);

    // Simultaneous rises ignored; a held button crosses once.
    do_reset(1);
    press(4'b1010, 1);
    press(4'b0100, CROSS + 3);

    // Saturation after 100 crossings.
    do_reset(1);
    repeat (100) press(4'b0100, 1);
    check_int("sat_moves", int'({MovesTens, MovesOnes}), 8'h99);

    // Reset during the second InTransit cycle aborts the crossing.
    do_reset(1);
    @(posedge Clock);
    #1 BtnC = 1'b1;
    @(posedge Clock);
    #1 BtnC = 1'b0;
    @(posedge Clock);
    #1 Reset = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0;
    model_reset();
    @(negedge Clock);
    check("abort", dut_vec(), 15'd0);
    press(4'b0100, 1);

    // Random play, resetting now and then once the game has ended.
    do_reset(1);
    repeat (150) begin
      logic [3:0] mask;
      if ((m_lost || m_won) && $urandom_range(0, 2) == 0) do_reset(1);
      if ($urandom_range(0, 3) == 0) mask = 4'($urandom_range(0, 15));
      else mask = 4'(1 << $urandom_range(0, 3));
      press(mask, $urandom_range(1, 3));
    end

    check_int("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
